// File: rtl/urv_mem_responder.sv
// urv_mem_responder: word RAM behind the uRV fetch and load/store buses.
// Optional URV_MEM_BUS_ERR_EN adds dm_err_o and defined out-of-range fetches.
module urv_mem_responder #(
  parameter int g_addr_bits   = 14,
  parameter int g_wait_states = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o
`ifdef URV_MEM_BUS_ERR_EN
  ,
  output logic        dm_err_o
`endif
);

  localparam int Words = 2 ** g_addr_bits;
  localparam logic [3:0] WaitInit = 4'(g_wait_states);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER
  } state_t;

  logic [31:0] mem_q [Words];

  logic [g_addr_bits-1:0] im_idx;
  logic [g_addr_bits-1:0] dm_idx;
  logic                   im_ok;
  logic                   dm_ok;
  logic                   accept;

  state_t                 state_q;
  logic [g_addr_bits-1:0] idx_q;
  logic                   ok_q;
  logic                   store_q;
  logic [31:0]            wdata_q;
  logic [3:0]             sel_q;
  logic [3:0]             cnt_q;

  logic unused_ok;
  assign unused_ok = ^{im_addr_i[1:0], dm_addr_i[1:0]};

  assign im_idx = im_addr_i[g_addr_bits+1:2];
  assign dm_idx = dm_addr_i[g_addr_bits+1:2];
  assign im_ok  = (im_addr_i[31:g_addr_bits+2] == '0);
  assign dm_ok  = (dm_addr_i[31:g_addr_bits+2] == '0);
  assign accept = dm_ready_o & (dm_store_i | dm_load_i);

  // Fetch reads with nonblocking semantics, so a same-edge store is not seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      im_data_o  <= '0;
      im_valid_o <= 1'b0;
    end else begin
      im_data_o  <= im_ok ? mem_q[im_idx] : '0;
`ifdef URV_MEM_BUS_ERR_EN
      im_valid_o <= 1'b1;
`else
      im_valid_o <= im_ok;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_XFER && store_q && ok_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      ok_q            <= 1'b0;
      store_q         <= 1'b0;
      wdata_q         <= '0;
      sel_q           <= '0;
      cnt_q           <= '0;
      dm_ready_o      <= 1'b0;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
`ifdef URV_MEM_BUS_ERR_EN
      dm_err_o        <= 1'b0;
`endif
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
`ifdef URV_MEM_BUS_ERR_EN
      dm_err_o        <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          // Ready rises one cycle after XFER, then drops on accept.
          dm_ready_o <= ~accept;
          if (accept) begin
            idx_q   <= dm_idx;
            ok_q    <= dm_ok;
            store_q <= dm_store_i;
            wdata_q <= dm_data_s_i;
            sel_q   <= dm_data_select_i;
            cnt_q   <= WaitInit;
            state_q <= (g_wait_states > 0) ? S_WAIT : S_XFER;
          end
        end
        S_WAIT: begin
          dm_ready_o <= 1'b0;
          cnt_q      <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          dm_ready_o <= 1'b0;
          if (store_q) begin
            dm_store_done_o <= 1'b1;
          end else begin
            dm_load_done_o <= 1'b1;
            dm_data_l_o    <= ok_q ? mem_q[idx_q] : '0;
          end
`ifdef URV_MEM_BUS_ERR_EN
          dm_err_o <= ~ok_q;
`endif
          state_q <= S_IDLE;
        end
        default: begin
          dm_ready_o <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_mem_responder.sv
// Directed bench for urv_mem_responder: instance A has no wait states,
// instance B has three.
module tb_urv_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_ia = '0, a_id, a_da = '0, a_dw = '0, a_dl;
  logic        a_iv, a_st = 1'b0, a_ld = 1'b0, a_rdy, a_ldn, a_sdn;
  logic [3:0]  a_sel = '0;
  logic [31:0] b_ia = '0, b_id, b_da = '0, b_dw = '0, b_dl;
  logic        b_iv, b_st = 1'b0, b_ld = 1'b0, b_rdy, b_ldn, b_sdn;
  logic [3:0]  b_sel = '0;
`ifdef URV_MEM_BUS_ERR_EN
  logic a_err, b_err;
`endif

  int vecs = 0;
  int errs = 0;

  urv_mem_responder #(.g_addr_bits(14), .g_wait_states(0)) u_a (
    .clk_i(clk), .rst_i(rst),
    .im_addr_i(a_ia), .im_data_o(a_id), .im_valid_o(a_iv),
    .dm_addr_i(a_da), .dm_data_s_i(a_dw), .dm_data_select_i(a_sel),
    .dm_store_i(a_st), .dm_load_i(a_ld), .dm_ready_o(a_rdy),
    .dm_data_l_o(a_dl), .dm_load_done_o(a_ldn),
`ifdef URV_MEM_BUS_ERR_EN
    .dm_err_o(a_err),
`endif
    .dm_store_done_o(a_sdn)
  );

  urv_mem_responder #(.g_addr_bits(14), .g_wait_states(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .im_addr_i(b_ia), .im_data_o(b_id), .im_valid_o(b_iv),
    .dm_addr_i(b_da), .dm_data_s_i(b_dw), .dm_data_select_i(b_sel),
    .dm_store_i(b_st), .dm_load_i(b_ld), .dm_ready_o(b_rdy),
    .dm_data_l_o(b_dl), .dm_load_done_o(b_ldn),
`ifdef URV_MEM_BUS_ERR_EN
    .dm_err_o(b_err),
`endif
    .dm_store_done_o(b_sdn)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic st, input logic ld, input logic [31:0] ad,
                       input logic [31:0] d, input logic [3:0] s);
    a_st = st; a_ld = ld; a_da = ad; a_dw = d; a_sel = s;
    tick();
    a_st = 1'b0; a_ld = 1'b0;
  endtask

  task automatic b_req(input logic st, input logic ld, input logic [31:0] ad,
                       input logic [31:0] d, input logic [3:0] s);
    b_st = st; b_ld = ld; b_da = ad; b_dw = d; b_sel = s;
    tick();
    b_st = 1'b0; b_ld = 1'b0;
  endtask

  task automatic b_wait(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(b_ldn || b_sdn) && n < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vecs++; if (a_iv !== 1'b0) begin errs++; $display("FAIL rst_iv got=%b exp=0", a_iv); end
    vecs++; if (a_id !== 32'h0) begin errs++; $display("FAIL rst_id got=%h exp=0", a_id); end
    vecs++; if (a_rdy !== 1'b0) begin errs++; $display("FAIL rst_rdy got=%b exp=0", a_rdy); end
    vecs++; if (a_dl !== 32'h0) begin errs++; $display("FAIL rst_dl got=%h exp=0", a_dl); end
    vecs++; if ({a_ldn, a_sdn} !== 2'b00) begin errs++; $display("FAIL rst_done got=%b exp=00", {a_ldn, a_sdn}); end
    vecs++; if (b_rdy !== 1'b0) begin errs++; $display("FAIL rst_b_rdy got=%b exp=0", b_rdy); end
    rst = 1'b0;
    vecs++; if (a_iv !== 1'b0) begin errs++; $display("FAIL rel_iv0 got=%b exp=0", a_iv); end
    tick();
    vecs++; if (a_iv !== 1'b1) begin errs++; $display("FAIL rel_iv1 got=%b exp=1", a_iv); end
    vecs++; if (a_rdy !== 1'b1) begin errs++; $display("FAIL rel_rdy got=%b exp=1", a_rdy); end
    vecs++; if (b_rdy !== 1'b1) begin errs++; $display("FAIL rel_b_rdy got=%b exp=1", b_rdy); end
  endtask

  task automatic test_store_load();
    a_req(1'b1, 1'b0, 32'h100, 32'h12345678, 4'hF);
    vecs++; if (a_rdy !== 1'b0) begin errs++; $display("FAIL sl_busy got=%b exp=0", a_rdy); end
    vecs++; if (a_sdn !== 1'b0) begin errs++; $display("FAIL sl_early got=%b exp=0", a_sdn); end
    tick();
    vecs++; if (a_sdn !== 1'b1) begin errs++; $display("FAIL sl_sdone got=%b exp=1", a_sdn); end
    vecs++; if (a_rdy !== 1'b0) begin errs++; $display("FAIL sl_rdy_t1 got=%b exp=0", a_rdy); end
    tick();
    vecs++; if (a_rdy !== 1'b1) begin errs++; $display("FAIL sl_rdy_t2 got=%b exp=1", a_rdy); end
    vecs++; if (a_sdn !== 1'b0) begin errs++; $display("FAIL sl_pulse got=%b exp=0", a_sdn); end
    a_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    tick();
    vecs++; if (a_ldn !== 1'b1) begin errs++; $display("FAIL sl_ldone got=%b exp=1", a_ldn); end
    vecs++; if (a_dl !== 32'h12345678) begin errs++; $display("FAIL sl_data got=%h exp=12345678", a_dl); end
    tick();
  endtask

  task automatic test_byte_lanes();
    a_req(1'b1, 1'b0, 32'h100, 32'h0000AB00, 4'b0010);
    tick(); tick();
    a_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    tick();
    vecs++; if (a_dl !== 32'h1234AB78) begin errs++; $display("FAIL bl_lane1 got=%h exp=1234ab78", a_dl); end
    tick();
    a_req(1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 4'b0000);
    tick();
    vecs++; if (a_sdn !== 1'b1) begin errs++; $display("FAIL bl_sel0_done got=%b exp=1", a_sdn); end
    tick();
    a_req(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    tick();
    vecs++; if (a_dl !== 32'h1234AB78) begin errs++; $display("FAIL bl_sel0_word got=%h exp=1234ab78", a_dl); end
    tick();
  endtask

  task automatic test_store_wins();
    a_req(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    tick();
    vecs++; if ({a_sdn, a_ldn} !== 2'b10) begin errs++; $display("FAIL sw_pulses got=%b exp=10", {a_sdn, a_ldn}); end
    tick();
    a_req(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
    tick();
    vecs++; if (a_dl !== 32'hCAFEF00D) begin errs++; $display("FAIL sw_data got=%h exp=cafef00d", a_dl); end
    tick();
  endtask

  task automatic test_fetch();
    a_ia = 32'h40;
    tick();
    vecs++; if (a_id !== 32'hCAFEF00D) begin errs++; $display("FAIL f_data got=%h exp=cafef00d", a_id); end
    vecs++; if (a_iv !== 1'b1) begin errs++; $display("FAIL f_valid got=%b exp=1", a_iv); end
    a_ia = 32'h103;
    tick();
    vecs++; if (a_id !== 32'h1234AB78) begin errs++; $display("FAIL f_lowbits got=%h exp=1234ab78", a_id); end
    a_ia = 32'h0001_0040;
    tick();
    vecs++; if (a_id !== 32'h0) begin errs++; $display("FAIL f_oor_data got=%h exp=0", a_id); end
`ifdef URV_MEM_BUS_ERR_EN
    vecs++; if (a_iv !== 1'b1) begin errs++; $display("FAIL f_oor_valid got=%b exp=1", a_iv); end
`else
    vecs++; if (a_iv !== 1'b0) begin errs++; $display("FAIL f_oor_valid got=%b exp=0", a_iv); end
`endif
    a_ia = 32'h40;
    a_req(1'b1, 1'b0, 32'h40, 32'h55AA55AA, 4'hF);
    tick();
    vecs++; if (a_id !== 32'hCAFEF00D) begin errs++; $display("FAIL f_rbw_old got=%h exp=cafef00d", a_id); end
    tick();
    vecs++; if (a_id !== 32'h55AA55AA) begin errs++; $display("FAIL f_rbw_new got=%h exp=55aa55aa", a_id); end
  endtask

  task automatic test_out_of_range();
    a_req(1'b1, 1'b0, 32'h0, 32'h11111111, 4'hF);
    tick(); tick();
    a_req(1'b0, 1'b1, 32'h0001_0000, 32'h0, 4'h0);
    tick();
    vecs++; if (a_ldn !== 1'b1) begin errs++; $display("FAIL oor_ldone got=%b exp=1", a_ldn); end
    vecs++; if (a_dl !== 32'h0) begin errs++; $display("FAIL oor_ldata got=%h exp=0", a_dl); end
`ifdef URV_MEM_BUS_ERR_EN
    vecs++; if (a_err !== 1'b1) begin errs++; $display("FAIL oor_err_ld got=%b exp=1", a_err); end
`endif
    tick();
    a_req(1'b1, 1'b0, 32'h0001_0000, 32'hDEADBEEF, 4'hF);
    tick();
    vecs++; if (a_sdn !== 1'b1) begin errs++; $display("FAIL oor_sdone got=%b exp=1", a_sdn); end
`ifdef URV_MEM_BUS_ERR_EN
    vecs++; if (a_err !== 1'b1) begin errs++; $display("FAIL oor_err_st got=%b exp=1", a_err); end
`endif
    tick();
    a_req(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick();
    vecs++; if (a_dl !== 32'h11111111) begin errs++; $display("FAIL oor_word0 got=%h exp=11111111", a_dl); end
`ifdef URV_MEM_BUS_ERR_EN
    vecs++; if (a_err !== 1'b0) begin errs++; $display("FAIL oor_err_ok got=%b exp=0", a_err); end
`endif
    tick();
  endtask

  task automatic test_wait_states();
    int n;
    logic exp_done;
    logic exp_rdy;
    b_req(1'b1, 1'b0, 32'h20, 32'h0BADF00D, 4'hF);
    b_wait(n);
    vecs++; if (n != 4) begin errs++; $display("FAIL ws_store_lat got=%0d exp=4", n); end
    tick();
    b_req(1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
    vecs++; if (b_rdy !== 1'b0) begin errs++; $display("FAIL ws_rdy_t0 got=%b exp=0", b_rdy); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_done = (k == 4);
      exp_rdy  = (k >= 5);
      vecs++; if (b_ldn !== exp_done) begin errs++; $display("FAIL ws_ldone k=%0d got=%b exp=%b", k, b_ldn, exp_done); end
      vecs++; if (b_rdy !== exp_rdy) begin errs++; $display("FAIL ws_rdy k=%0d got=%b exp=%b", k, b_rdy, exp_rdy); end
      if (k == 4) begin
        vecs++; if (b_dl !== 32'h0BADF00D) begin errs++; $display("FAIL ws_data got=%h exp=0badf00d", b_dl); end
      end
      b_ld = (k == 1);
      b_da = '0;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    b_req(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    b_wait(n);
    tick();
    b_req(1'b1, 1'b0, 32'h80, 32'hFFFFFFFF, 4'hF);
    tick();
    rst = 1'b1;
    tick();
    vecs++; if (b_sdn !== 1'b0) begin errs++; $display("FAIL rm_sdone got=%b exp=0", b_sdn); end
    vecs++; if (b_rdy !== 1'b0) begin errs++; $display("FAIL rm_rdy got=%b exp=0", b_rdy); end
    vecs++; if (b_iv !== 1'b0) begin errs++; $display("FAIL rm_iv got=%b exp=0", b_iv); end
    tick();
    rst = 1'b0;
    vecs++; if (b_iv !== 1'b0) begin errs++; $display("FAIL rm_iv_rel got=%b exp=0", b_iv); end
    seen = 0;
    tick();
    vecs++; if (b_iv !== 1'b1) begin errs++; $display("FAIL rm_iv_2nd got=%b exp=1", b_iv); end
    if (b_sdn) seen++;
    repeat (6) begin
      tick();
      if (b_sdn) seen++;
    end
    vecs++; if (seen != 0) begin errs++; $display("FAIL rm_no_done got=%0d exp=0", seen); end
    b_req(1'b0, 1'b1, 32'h80, 32'h0, 4'h0);
    b_wait(n);
    vecs++; if (n != 4) begin errs++; $display("FAIL rm_ld_lat got=%0d exp=4", n); end
    vecs++; if (b_dl !== 32'h0) begin errs++; $display("FAIL rm_word got=%h exp=0", b_dl); end
    a_req(1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
    tick();
    vecs++; if (a_dl !== 32'h55AA55AA) begin errs++; $display("FAIL rm_ram_kept got=%h exp=55aa55aa", a_dl); end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_store_wins();
    test_fetch();
    test_out_of_range();
    test_wait_states();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
